// File: rtl/ccd_tgen_param.sv
// Run-time programmable CCD timing generator: V2 transfer, per-line vertical shift,
// horizontal readout, optional shutter line and FDG line skipping, with AFE syncs.
module ccd_tgen_param #(
  parameter int CNTW   = 16,
  parameter int SUBPIX = 4,
  parameter int TVE    = 4,
  parameter int HSW    = 2,
  parameter int SKIPW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_cont,
  input  logic [8*CNTW-1:0] cfg_tim,
  input  logic [CNTW-1:0]   cfg_hpix,
  input  logic [CNTW-1:0]   cfg_vpix,
  input  logic [SKIPW-1:0]  cfg_vskip,
  input  logic              cfg_eshut_en,
  input  logic [CNTW-1:0]   cfg_eshut_ln,
  output logic              busy,
  output logic              frame_done,
  output logic [CNTW-1:0]   line_cnt,
  output logic              dvp_hsync,
  output logic              dvp_vsync,
  output logic              tcon_v1,
  output logic              tcon_v2,
  output logic              tcon_v23,
  output logic              tcon_fdg,
  output logic              tcon_strobe,
  output logic              tcon_h1,
  output logic              tcon_h2,
  output logic              tcon_rg
);

  localparam int LSUB = $clog2(SUBPIX);
  localparam int HW   = CNTW + LSUB + 2;
  localparam int VW   = CNTW + 1;

  typedef logic [HW-1:0] hw_t;
  typedef logic [VW-1:0] vw_t;
  typedef enum logic [2:0] {
    S_IDLE, S_XFER, S_VSHIFT, S_ESHUT, S_ACTIVE, S_HBP, S_SKIP
  } state_t;

  localparam hw_t TVE_H = hw_t'(TVE);
  localparam hw_t HSW_H = hw_t'(HSW);
  localparam hw_t SUB_H = hw_t'(SUBPIX);

  function automatic hw_t ext(input logic [CNTW-1:0] x);
    return {{(HW-CNTW){1'b0}}, x};
  endfunction

  state_t           state_q, state_d;
  hw_t              h_q, h_d;
  vw_t              v_q, v_d;
  logic [SKIPW-1:0] sk_q, sk_d;
  logic             first_q, first_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             v1_q, v1_d, v2_q, v2_d, v23_q, v23_d, fdg_q, fdg_d;
  logic             strobe_q, strobe_d, h1_q, h1_d, h2_q, h2_d, rg_q, rg_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             load, frame_end;

  // Shadow configuration, refreshed only when a frame is launched.
  logic [8*CNTW-1:0] tim_q, tim_d;
  logic [CNTW-1:0]   hpix_q, hpix_d, vpix_q, vpix_d, eln_q, eln_d;
  logic [SKIPW-1:0]  vskip_q, vskip_d;
  logic              een_q, een_d, cont_q, cont_d;

  hw_t t3p, tv3rd, t3d, tvccd, thd, ts, tsd, tfd;
  hw_t len_x, len_l, len_e, len_a, hp1;
  vw_t v_inc, vpix_x;
  logic vwin_v1, vwin_v2;

  always_comb begin
    t3p   = ext(tim_q[0*CNTW +: CNTW]);
    tv3rd = ext(tim_q[1*CNTW +: CNTW]);
    t3d   = ext(tim_q[2*CNTW +: CNTW]);
    tvccd = ext(tim_q[3*CNTW +: CNTW]);
    thd   = ext(tim_q[4*CNTW +: CNTW]);
    ts    = ext(tim_q[5*CNTW +: CNTW]);
    tsd   = ext(tim_q[6*CNTW +: CNTW]);
    tfd   = ext(tim_q[7*CNTW +: CNTW]);
    len_x = t3p + tv3rd + t3d;
    len_l = tvccd + thd;
    len_e = ts + tsd;
    len_a = (ext(hpix_q) + hw_t'(1)) << LSUB;
    hp1   = h_q + hw_t'(1);
    v_inc = v_q + vw_t'(1);
    vpix_x = {1'b0, vpix_q};
    // Guard comparisons are rearranged (h+TVE vs. bound) so no subtraction can wrap.
    vwin_v1 = (h_q >= TVE_H) && (h_q + TVE_H < tvccd);
    vwin_v2 = (h_q < tvccd);
  end

  // Sequencer: "last" tests use h+1 >= length so a zero-length window still advances.
  always_comb begin
    state_d   = state_q;
    h_d       = hp1;
    v_d       = v_q;
    sk_d      = sk_q;
    first_d   = first_q;
    stop_d    = stop_q | stop;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        h_d    = '0;
        stop_d = start & stop;
        if (start) begin
          state_d = S_XFER;
          load    = 1'b1;
          v_d     = '0;
          first_d = 1'b1;
        end
      end
      S_XFER: begin
        if (hp1 >= len_x) begin
          state_d = S_VSHIFT;
          h_d     = '0;
        end
      end
      S_VSHIFT: begin
        if (hp1 >= len_l) begin
          h_d     = '0;
          first_d = 1'b0;
          state_d = (een_q && (v_q == {1'b0, eln_q})) ? S_ESHUT : S_ACTIVE;
        end
      end
      S_ESHUT: begin
        if (hp1 >= len_e) begin
          state_d = S_ACTIVE;
          h_d     = '0;
        end
      end
      S_ACTIVE: begin
        if (hp1 >= len_a) begin
          state_d = S_HBP;
          h_d     = '0;
        end
      end
      S_HBP: begin
        if (hp1 >= SUB_H) begin
          h_d = '0;
          v_d = v_inc;
          if (v_inc > vpix_x) begin
            frame_end = 1'b1;
          end else if (vskip_q != '0) begin
            state_d = S_SKIP;
            sk_d    = '0;
          end else begin
            state_d = S_VSHIFT;
          end
        end
      end
      S_SKIP: begin
        if (sk_q == '0) begin
          if (hp1 >= tfd) begin
            h_d  = '0;
            sk_d = SKIPW'(1);
          end
        end else if (hp1 >= len_l) begin
          h_d = '0;
          v_d = v_inc;
          if (v_inc > vpix_x) begin
            frame_end = 1'b1;
          end else if (sk_q == vskip_q) begin
            state_d = S_VSHIFT;
          end else begin
            sk_d = sk_q + SKIPW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        h_d     = '0;
      end
    endcase
    if (frame_end) begin
      h_d    = '0;
      v_d    = '0;
      stop_d = 1'b0;
      if (cont_q && !stop_q && !stop) begin
        state_d = S_XFER;
        load    = 1'b1;
        first_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
    busy_d = (state_d != S_IDLE);
    done_d = frame_end;
  end

  // Output decode from the current state/h_cnt; registered below.
  always_comb begin
    v1_d = 1'b1; v2_d = 1'b0; v23_d = 1'b0; fdg_d = 1'b0; strobe_d = 1'b0;
    h1_d = 1'b1; h2_d = 1'b0; rg_d = 1'b0; hs_d = 1'b0; vs_d = 1'b0;
    if (state_q != S_IDLE) rg_d = (h_q[LSUB-1:0] == '0);
    case (state_q)
      S_XFER: begin
        v2_d  = 1'b1;
        v1_d  = !((h_q >= t3p) && (h_q + TVE_H < t3p + tv3rd));
        v23_d = (h_q + TVE_H >= t3p) && (h_q < t3p + tv3rd);
      end
      S_VSHIFT: begin
        v1_d = !vwin_v1;
        v2_d = vwin_v2;
        hs_d = (h_q < HSW_H);
        vs_d = first_q;
      end
      S_ESHUT:  strobe_d = (h_q < ts);
      S_ACTIVE: begin
        h1_d = !h_q[LSUB-1];
        h2_d = h_q[LSUB-1];
      end
      S_SKIP: begin
        if (sk_q == '0) begin
          fdg_d = 1'b1;
        end else begin
          v1_d  = !vwin_v1;
          v2_d  = vwin_v2;
          fdg_d = !((sk_q == vskip_q) && (h_q + tfd >= len_l));
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tim_d   = load ? cfg_tim      : tim_q;
    hpix_d  = load ? cfg_hpix     : hpix_q;
    vpix_d  = load ? cfg_vpix     : vpix_q;
    vskip_d = load ? cfg_vskip    : vskip_q;
    een_d   = load ? cfg_eshut_en : een_q;
    eln_d   = load ? cfg_eshut_ln : eln_q;
    cont_d  = load ? cfg_cont     : cont_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      h_q      <= '0;
      v_q      <= '0;
      sk_q     <= '0;
      first_q  <= 1'b0;
      stop_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      v1_q     <= 1'b1;
      v2_q     <= 1'b0;
      v23_q    <= 1'b0;
      fdg_q    <= 1'b0;
      strobe_q <= 1'b0;
      h1_q     <= 1'b1;
      h2_q     <= 1'b0;
      rg_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      sk_q     <= sk_d;
      first_q  <= first_d;
      stop_q   <= stop_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v23_q    <= v23_d;
      fdg_q    <= fdg_d;
      strobe_q <= strobe_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      rg_q     <= rg_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  always_ff @(posedge clk) begin
    tim_q   <= tim_d;
    hpix_q  <= hpix_d;
    vpix_q  <= vpix_d;
    vskip_q <= vskip_d;
    een_q   <= een_d;
    eln_q   <= eln_d;
    cont_q  <= cont_d;
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign line_cnt    = v_q[CNTW-1:0];
  assign dvp_hsync   = hs_q;
  assign dvp_vsync   = vs_q;
  assign tcon_v1     = v1_q;
  assign tcon_v2     = v2_q;
  assign tcon_v23    = v23_q;
  assign tcon_fdg    = fdg_q;
  assign tcon_strobe = strobe_q;
  assign tcon_h1     = h1_q;
  assign tcon_h2     = h2_q;
  assign tcon_rg     = rg_q;

endmodule

// File: tb/tb_ccd_tgen_param.sv
// Directed bench for ccd_tgen_param: per-frame output tallies against hand-computed counts.
module tb_ccd_tgen_param;
  localparam int CNTW  = 16;
  localparam int SKIPW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, cfg_cont, cfg_eshut_en;
  logic [8*CNTW-1:0] cfg_tim;
  logic [CNTW-1:0]   cfg_hpix, cfg_vpix, cfg_eshut_ln, line_cnt;
  logic [SKIPW-1:0]  cfg_vskip;
  logic busy, frame_done, dvp_hsync, dvp_vsync, tcon_v1, tcon_v2, tcon_v23;
  logic tcon_fdg, tcon_strobe, tcon_h1, tcon_h2, tcon_rg;

  int checks = 0;
  int failures = 0;

  // Per-run tallies
  int c_busy, c_v1l, c_v2, c_v23, c_fdg, c_str, c_h2, c_rg, c_hs, c_vs, c_fd, c_sbad, c_hr;
  int fd_t[4];
  int hr_t[8];
  int timeout;

  ccd_tgen_param dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_cont(cfg_cont),
    .cfg_tim(cfg_tim), .cfg_hpix(cfg_hpix), .cfg_vpix(cfg_vpix), .cfg_vskip(cfg_vskip),
    .cfg_eshut_en(cfg_eshut_en), .cfg_eshut_ln(cfg_eshut_ln),
    .busy(busy), .frame_done(frame_done), .line_cnt(line_cnt),
    .dvp_hsync(dvp_hsync), .dvp_vsync(dvp_vsync),
    .tcon_v1(tcon_v1), .tcon_v2(tcon_v2), .tcon_v23(tcon_v23), .tcon_fdg(tcon_fdg),
    .tcon_strobe(tcon_strobe), .tcon_h1(tcon_h1), .tcon_h2(tcon_h2), .tcon_rg(tcon_rg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_tim(input int t3p, input int tv3rd, input int t3d, input int tvccd,
                         input int thd, input int ts, input int tsd, input int tfd);
    cfg_tim = {tfd[15:0], tsd[15:0], ts[15:0], thd[15:0],
               tvccd[15:0], t3d[15:0], tv3rd[15:0], t3p[15:0]};
  endtask

  // Launches a frame (start, optionally with stop), then tallies outputs at each
  // negedge until busy has been low for 3 samples or maxc samples have elapsed.
  task automatic run_frame(input int maxc, input bit stop_with_start,
                           input int stop_at, input int chg_at, input int xs_at);
    int n, idle_run;
    bit seen, hs_prev, fin;
    c_busy = 0; c_v1l = 0; c_v2 = 0; c_v23 = 0; c_fdg = 0; c_str = 0; c_h2 = 0;
    c_rg = 0; c_hs = 0; c_vs = 0; c_fd = 0; c_sbad = 0; c_hr = 0; timeout = 0;
    for (int i = 0; i < 4; i++) fd_t[i] = 0;
    for (int i = 0; i < 8; i++) hr_t[i] = 0;
    n = 0; idle_run = 0; seen = 0; hs_prev = 0; fin = 0;
    @(negedge clk);
    start = 1'b1;
    stop  = stop_with_start;
    while (!fin) begin
      @(negedge clk);
      n++;
      if (busy) begin seen = 1; c_busy++; end
      if (!tcon_v1) c_v1l++;
      if (tcon_v2) c_v2++;
      if (tcon_v23) c_v23++;
      if (tcon_fdg) c_fdg++;
      if (tcon_strobe) c_str++;
      if (tcon_strobe && line_cnt != 16'd1) c_sbad++;
      if (tcon_h2) c_h2++;
      if (tcon_rg) c_rg++;
      if (dvp_hsync) c_hs++;
      if (dvp_vsync) c_vs++;
      if (frame_done) begin
        if (c_fd < 4) fd_t[c_fd] = n;
        c_fd++;
      end
      if (dvp_hsync && !hs_prev) begin
        if (c_hr < 8) hr_t[c_hr] = n;
        c_hr++;
      end
      hs_prev = dvp_hsync;
      start = (n == xs_at);
      stop  = (n == stop_at);
      if (n == chg_at) cfg_hpix = 16'd7;
      if (seen && !busy) idle_run++; else idle_run = 0;
      if (idle_run >= 3) fin = 1;
      else if (n >= maxc) begin timeout = 1; fin = 1; end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic base_cfg();
    cfg_cont = 1'b0; cfg_eshut_en = 1'b0; cfg_eshut_ln = 16'd0;
    cfg_hpix = 16'd3; cfg_vpix = 16'd2; cfg_vskip = '0;
    set_tim(40, 12, 20, 8, 8, 6, 2, 4);
  endtask

  task automatic check_t1(input string p);
    chk({p, "_timeout"}, timeout, 0);
    chk({p, "_busy_cycles"}, c_busy, 180);
    chk({p, "_frame_done"}, c_fd, 1);
    chk({p, "_fd_time"}, fd_t[0], 181);
    chk({p, "_vsync"}, c_vs, 16);
    chk({p, "_v2"}, c_v2, 96);
    chk({p, "_v1_low"}, c_v1l, 8);
    chk({p, "_v23"}, c_v23, 16);
    chk({p, "_h2"}, c_h2, 24);
    chk({p, "_rg"}, c_rg, 45);
    chk({p, "_hsync"}, c_hs, 6);
    chk({p, "_hsync_rises"}, c_hr, 3);
    chk({p, "_line_len"}, hr_t[1] - hr_t[0], 36);
    chk({p, "_fdg"}, c_fdg, 0);
    chk({p, "_strobe"}, c_str, 0);
    chk({p, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    base_cfg();
    #12;
    chk("rst_outs", int'({busy, frame_done, dvp_hsync, dvp_vsync, tcon_v1, tcon_v2, tcon_v23,
                          tcon_fdg, tcon_strobe, tcon_h1, tcon_h2, tcon_rg}), 12'b0000_1000_0100);
    chk("rst_line_cnt", int'(line_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic single frame
    run_frame(2000, 1'b0, -1, -1, -1);
    check_t1("t1");

    // Shutter on line 1
    cfg_eshut_en = 1'b1; cfg_eshut_ln = 16'd1;
    run_frame(2000, 1'b0, -1, -1, -1);
    chk("t2_timeout", timeout, 0);
    chk("t2_busy_cycles", c_busy, 188);
    chk("t2_strobe", c_str, 6);
    chk("t2_strobe_line", c_sbad, 0);
    chk("t2_line0_len", hr_t[1] - hr_t[0], 36);
    chk("t2_line1_len", hr_t[2] - hr_t[1], 44);
    chk("t2_frame_done", c_fd, 1);

    // Line skipping
    base_cfg();
    cfg_vpix = 16'd5; cfg_vskip = 4'd2;
    run_frame(2000, 1'b0, -1, -1, -1);
    chk("t3_timeout", timeout, 0);
    chk("t3_busy_cycles", c_busy, 216);
    chk("t3_fdg", c_fdg, 64);
    chk("t3_hsync_rises", c_hr, 2);
    chk("t3_read_gap", hr_t[1] - hr_t[0], 72);
    chk("t3_v2", c_v2, 120);
    chk("t3_vsync", c_vs, 16);
    chk("t3_frame_done", c_fd, 1);
    chk("t3_fd_time", fd_t[0], 217);

    // Continuous with stop in frame 1; hpix change during frame 0 applies to frame 1
    base_cfg();
    cfg_cont = 1'b1;
    run_frame(3000, 1'b0, 250, 10, -1);
    chk("t4_timeout", timeout, 0);
    chk("t4_frame_done", c_fd, 2);
    chk("t4_fd0_time", fd_t[0], 181);
    chk("t4_fd1_time", fd_t[1], 409);
    chk("t4_busy_cycles", c_busy, 408);
    chk("t4_h2", c_h2, 24 + 48);
    repeat (20) @(negedge clk);
    chk("t4_idle", int'(busy), 0);

    // Reset mid-ACTIVE
    base_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (94) @(negedge clk);
    chk("t5_pre_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", int'({busy, frame_done, dvp_hsync, dvp_vsync, tcon_v1, tcon_v2, tcon_v23,
                             tcon_fdg, tcon_strobe, tcon_h1, tcon_h2, tcon_rg}), 12'b0000_1000_0100);
    begin
      int fdc;
      fdc = 0;
      repeat (4) begin @(negedge clk); if (frame_done) fdc++; end
      rst_n = 1'b1;
      repeat (6) begin @(negedge clk); if (frame_done || busy) fdc++; end
      chk("t5_no_done", fdc, 0);
    end
    run_frame(2000, 1'b0, -1, -1, -1);
    check_t1("t5");

    // vpix=0 with a redundant start while busy
    base_cfg();
    cfg_vpix = 16'd0;
    run_frame(2000, 1'b0, -1, -1, 20);
    chk("t6_timeout", timeout, 0);
    chk("t6_busy_cycles", c_busy, 108);
    chk("t6_frame_done", c_fd, 1);
    chk("t6_hsync_rises", c_hr, 1);

    // start+stop together in continuous mode: exactly one frame
    cfg_cont = 1'b1;
    run_frame(2000, 1'b1, -1, -1, -1);
    chk("t6b_timeout", timeout, 0);
    chk("t6b_busy_cycles", c_busy, 108);
    chk("t6b_frame_done", c_fd, 1);
    repeat (10) @(negedge clk);
    chk("t6b_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
